// File: rtl/arbitro_mux2x1.sv
// arbitro_mux2x1 -- two-requester arbiter feeding a registered 2:1 mux.
//
// Two valid/ready producers (valid1/e1/ready1, valid2/e2/ready2) share one
// registered output (salMux/salValid/sel) consumed through salReady.
// A word is taken whenever the output register is empty or is being drained
// in the same cycle, so sustained traffic moves one word per clock.
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   valid1/e1 : requester 1 valid and 32-bit data; ready1 = accepted this cycle
//   valid2/e2 : requester 2 valid and 32-bit data; ready2 = accepted this cycle
//   salMux    : registered output data
//   salValid  : salMux holds an unconsumed word
//   salReady  : consumer takes salMux this cycle
//   sel       : registered source of salMux (0 = e1, 1 = e2)
//
// Build option
//   ARBITRO_PRIORIDAD_FIJA_EN : when defined, e1 always wins contention and the
//                               round-robin pointer is not built. Undefined by
//                               default (round-robin).
//
// State | meaning
// ------+-----------------------------------------------
// LIBRE   | output register empty, salValid = 0
// OCUPADO | output register holds a word, salValid = 1

module arbitro_mux2x1 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid1,
  input  logic [31:0] e1,
  output logic        ready1,
  input  logic        valid2,
  input  logic [31:0] e2,
  output logic        ready2,
  output logic [31:0] salMux,
  output logic        salValid,
  input  logic        salReady,
  output logic        sel
);

  typedef enum logic {
    LIBRE   = 1'b0,
    OCUPADO = 1'b1
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [31:0] sal_mux_q, sal_mux_d;
  logic        sel_q, sel_d;
  logic        acepta;
  logic        grant1, grant2;

`ifndef ARBITRO_PRIORIDAD_FIJA_EN
  // 1 = last grant went to e2, so the next contested grant goes to e1.
  logic        ultimo_q, ultimo_d;
`endif

  // rst_n gates acceptance so no ready can escape while reset is held.
  always_comb begin
    acepta = rst_n & ((estado_q == LIBRE) | salReady);
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    grant1 = acepta & valid1;
    grant2 = acepta & valid2 & ~valid1;
`else
    grant1 = acepta & valid1 & (~valid2 | ultimo_q);
    grant2 = acepta & valid2 & (~valid1 | ~ultimo_q);
`endif
  end

  always_comb begin
    estado_d  = estado_q;
    sal_mux_d = sal_mux_q;
    sel_d     = sel_q;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
    ultimo_d  = ultimo_q;
`endif
    if (grant1 | grant2) begin
      // Covers both the LIBRE load and the back-to-back reload while draining.
      estado_d  = OCUPADO;
      sal_mux_d = grant2 ? e2 : e1;
      sel_d     = grant2;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
      ultimo_d  = grant2;
`endif
    end else if ((estado_q == OCUPADO) && salReady) begin
      estado_d = LIBRE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= LIBRE;
      sal_mux_q <= 32'h0;
      sel_q     <= 1'b0;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
      ultimo_q  <= 1'b1;
`endif
    end else begin
      estado_q  <= estado_d;
      sal_mux_q <= sal_mux_d;
      sel_q     <= sel_d;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
      ultimo_q  <= ultimo_d;
`endif
    end
  end

  assign ready1   = grant1;
  assign ready2   = grant2;
  assign salMux   = sal_mux_q;
  assign salValid = (estado_q == OCUPADO);
  assign sel      = sel_q;

endmodule

// File: tb/tb_arbitro_mux2x1.sv
module tb_arbitro_mux2x1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid1 = 1'b0, valid2 = 1'b0, salReady = 1'b0;
  logic [31:0] e1 = 32'h0, e2 = 32'h0;
  logic        ready1, ready2, salValid, sel;
  logic [31:0] salMux;

  int errs = 0;
  int checks = 0;

  arbitro_mux2x1 dut (
    .clk(clk), .rst_n(rst_n),
    .valid1(valid1), .e1(e1), .ready1(ready1),
    .valid2(valid2), .e2(e2), .ready2(ready2),
    .salMux(salMux), .salValid(salValid), .salReady(salReady), .sel(sel)
  );

  always #5 clk = ~clk;

  // Reference model: output register contents plus who won last.
  bit          m_valid = 1'b0;
  logic [31:0] m_mux = 32'h0;
  bit          m_sel = 1'b0;
  int          m_last = 2;
  bit          m_acc1 = 1'b0, m_acc2 = 1'b0;

  function automatic int exp_grant();
    if (rst_n !== 1'b1) return 0;
    if (m_valid && !salReady) return 0;
    if (valid1 && valid2) begin
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
      return 1;
`else
      return (m_last == 1) ? 2 : 1;
`endif
    end
    if (valid1) return 1;
    if (valid2) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_mux = 32'h0; m_sel = 1'b0; m_last = 2;
      m_acc1 = 1'b0; m_acc2 = 1'b0;
    end else begin
      int g;
      g = exp_grant();
      m_acc1 = (g == 1);
      m_acc2 = (g == 2);
      if (g != 0) begin
        m_valid = 1'b1;
        m_mux   = (g == 1) ? e1 : e2;
        m_sel   = (g == 2);
        m_last  = g;
      end else if (m_valid && salReady) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, inputs are stable mid-cycle.
  always @(negedge clk) begin
    int g;
    g = exp_grant();
    chk("model ready1", {31'b0, ready1}, {31'b0, g == 1});
    chk("model ready2", {31'b0, ready2}, {31'b0, g == 2});
    chk("model salValid", {31'b0, salValid}, {31'b0, m_valid});
    chk("model salMux", salMux, m_mux);
    chk("model sel", {31'b0, sel}, {31'b0, m_sel});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic v1, input logic [31:0] d1,
                        input logic v2, input logic [31:0] d2, input logic sr);
    valid1 = v1; e1 = d1; valid2 = v2; e2 = d2; salReady = sr;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  logic [31:0] seq_mux [4];
  logic        seq_sel [4];

  initial begin
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    seq_mux = '{32'h1, 32'h1, 32'h1, 32'h1};
    seq_sel = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    seq_mux = '{32'h1, 32'h2, 32'h1, 32'h2};
    seq_sel = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

    // Reset state, with a request pending that must not be acknowledged.
    set_in(1'b1, 32'h55, 1'b1, 32'h66, 1'b1);
    #3;
    chk("reset ready1", {31'b0, ready1}, 32'h0);
    chk("reset ready2", {31'b0, ready2}, 32'h0);
    chk("reset salValid", {31'b0, salValid}, 32'h0);
    chk("reset salMux", salMux, 32'h0);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    rst_n = 1'b1;

    // Single source.
    set_in(1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
    #1 chk("single ready1", {31'b0, ready1}, 32'h1);
    cyc();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("single salValid", {31'b0, salValid}, 32'h1);
    chk("single salMux", salMux, 32'hDEADBEEF);
    chk("single sel", {31'b0, sel}, 32'h0);

    // Contention right after reset.
    do_reset();
    set_in(1'b1, 32'h1, 1'b1, 32'h2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("contend salMux", salMux, seq_mux[i]);
      chk("contend sel", {31'b0, sel}, {31'b0, seq_sel[i]});
    end

    // Backpressure.
    set_in(1'b1, 32'hA5, 1'b0, 32'h0, 1'b1);
    cyc();
    set_in(1'b0, 32'h0, 1'b1, 32'hB2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp ready2 low", {31'b0, ready2}, 32'h0);
      cyc();
      chk("bp salMux held", salMux, 32'hA5);
      chk("bp salValid", {31'b0, salValid}, 32'h1);
    end
    salReady = 1'b1;
    #1 chk("bp ready2 high", {31'b0, ready2}, 32'h1);
    cyc();
    chk("bp salMux e2", salMux, 32'hB2);
    chk("bp sel e2", {31'b0, sel}, 32'h1);

    // Drain.
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cyc();
    chk("drain salValid", {31'b0, salValid}, 32'h0);
    chk("drain salMux", salMux, 32'hB2);
    salReady = 1'b0;
    cyc();
    chk("libre ignores salReady", {31'b0, salValid}, 32'h0);

    // Async reset mid-transfer.
    set_in(1'b0, 32'h0, 1'b1, 32'h7, 1'b1);
    cyc();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("pre-reset salValid", {31'b0, salValid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async salValid", {31'b0, salValid}, 32'h0);
    chk("async salMux", salMux, 32'h0);
    chk("async sel", {31'b0, sel}, 32'h0);
    cyc();
    rst_n = 1'b1;
    set_in(1'b1, 32'h11, 1'b1, 32'h22, 1'b1);
    cyc();
    chk("post-reset winner", salMux, 32'h11);
    chk("post-reset sel", {31'b0, sel}, 32'h0);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cyc();

    // Randomized traffic; requesters hold until accepted.
    for (int i = 0; i < 600; i++) begin
      cyc();
      if (!valid1 || m_acc1) begin
        valid1 = ($urandom_range(0, 99) < 60);
        e1 = $urandom;
      end
      if (!valid2 || m_acc2) begin
        valid2 = ($urandom_range(0, 99) < 60);
        e2 = $urandom;
      end
      salReady = ($urandom_range(0, 99) < 70);
      if ((i % 97) == 50) begin
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
      end
    end

    cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
